// File: rtl/alu_operand_seq.sv
// ---------------------------------------------------------------------------
// alu_operand_seq
//   Sequencing front/back end for a combinational ALU/comparator stage.
//   Two operand beats (A with opcode, then B) arrive on a valid/ready bus and
//   are held on the ALU inputs for a settle window. The ALU result is then
//   registered and offered downstream on a valid/ready result port, together
//   with a zero flag and a count of completed result handshakes.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous abort back to LOAD_A
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      operand beat accepted when in_valid & in_ready
//   in_data    in   WIDTH  operand value (A on first beat, B on second)
//   in_op      in   OPW    opcode, sampled on the A beat only
//   alu_a      out  WIDTH  registered operand A to the ALU
//   alu_b      out  WIDTH  registered operand B to the ALU
//   alu_op     out  OPW    registered opcode to the ALU
//   alu_x      in   WIDTH  combinational ALU result
//   res_valid  out  1      result valid
//   res_ready  in   1      downstream accepts result when res_valid & res_ready
//   res_data   out  WIDTH  registered ALU result
//   res_zero   out  1      registered (alu_x == 0) at capture
//   op_count   out  8      completed result handshakes, modulo 256
//
// State table
//   state   | meaning
//   LOAD_A  | waiting for operand A + opcode beat
//   LOAD_B  | waiting for operand B beat
//   SETTLE  | ALU inputs held, settle timer counting down
//   HOLD    | result presented, waiting for downstream handshake
// ---------------------------------------------------------------------------
module alu_operand_seq #(
    parameter int WIDTH         = 6,
    parameter int OPW           = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [7:0]       op_count
);

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Settle window is 1..15 cycles, so a 4-bit down-counter covers it; the
    // counter is loaded with SETTLE_CYCLES-1 and the capture happens on the
    // cycle it reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       beat;
    logic       res_hs;
    logic       cnt_tc;

    // in_ready decodes state only, so no path exists from in_valid/res_ready.
    assign in_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign beat     = in_valid && in_ready;
    assign res_hs   = res_valid && res_ready;
    assign cnt_tc   = (cnt == 4'd0);

    // Control: state, settle timer, result valid and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD_A;
            cnt       <= 4'd0;
            res_valid <= 1'b0;
            op_count  <= 8'd0;
        end else if (flush) begin
            // Flush beats any concurrent beat or handshake; the count is
            // left untouched because the result was never delivered.
            state     <= ST_LOAD_A;
            cnt       <= 4'd0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: begin
                    if (beat) begin
                        state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (beat) begin
                        cnt   <= CNT_LOAD;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_tc) begin
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (res_hs) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= ST_LOAD_A;
                    end
                end
                default: begin
                    state     <= ST_LOAD_A;
                    cnt       <= 4'd0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers: only written by an accepted beat, so they remain
    // stable on the ALU inputs through SETTLE and HOLD and across flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_op <= '0;
        end else if (!flush && beat && (state == ST_LOAD_A)) begin
            alu_a  <= in_data;
            alu_op <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_b <= '0;
        end else if (!flush && beat && (state == ST_LOAD_B)) begin
            alu_b <= in_data;
        end
    end

    // Result capture at the end of the settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_zero <= 1'b0;
        end else if (!flush && (state == ST_SETTLE) && cnt_tc) begin
            res_data <= alu_x;
            res_zero <= (alu_x == '0);
        end
    end

endmodule
